// File: rtl/csr_counters.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csr_counters                                                    |
// | Brief    : Counter/timer CSR bank: mcycle, minstret, hpm counters,         |
// |            mcountinhibit, mcounteren, mtime/mtimecmp and machine timer.    |
// | Option   : CSR_USER_COUNTERS_EN adds read-only user shadows at C00/C80.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module csr_counters #(
  parameter int XLEN      = 32,
  parameter int N_HPM     = 4,
  parameter int N_EVENTS  = 8,
  parameter int TIMER_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          current_mode,
  input  logic [11:0]         csr_address_r,
  output logic [XLEN-1:0]     csr_data,
  output logic                csr_hit,
  output logic                csr_illegal,
  input  logic                csr_we_r,
  input  logic [11:0]         csr_address_wb,
  input  logic [XLEN-1:0]     csr_wb,
  input  logic                csr_we,
  input  logic                exception_pending,
  input  logic                stall,
  input  logic                instr_retire,
  input  logic [N_EVENTS-1:0] hpm_event,
  output logic                m_timer
);

  localparam logic [1:0]  C_MODE_M   = 2'b11;
  localparam int          C_CW       = 2 * XLEN;
  localparam int          C_NH       = (N_HPM > 0) ? N_HPM : 1;
  localparam int          C_PW       = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [63:0] C_INH_ALL  = (64'd1 << (3 + N_HPM)) - 64'd1;
  localparam logic [31:0] C_INH_MASK = C_INH_ALL[31:0] & 32'hFFFF_FFFD;

  logic [C_CW-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [C_CW-1:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [C_CW-1:0] hpm_q [C_NH];
  logic [C_CW-1:0] hpm_d [C_NH];
  logic [7:0]      event_q [C_NH];
  logic [7:0]      event_d [C_NH];
  logic [31:0]     inhibit_q, inhibit_d, counteren_q, counteren_d;
  logic [C_PW-1:0] presc_q, presc_d;
  logic            m_timer_q;

  logic            w_commit, w_wr_lo, w_wr_hi, w_tick;
  logic [4:0]      w_wb_idx, w_rd_idx;
  logic [C_NH-1:0] w_ev_hit;
  logic            w_rd_lo, w_rd_hi, w_rd_inh, w_rd_evt, w_rd_en, w_rd_tim;
  logic            w_mach, w_usr, w_priv_fail;
  logic [C_CW-1:0] w_cnt_val;
  logic [XLEN-1:0] w_val;

  // A write to one half replaces that half only and suppresses the increment.
  function automatic logic [C_CW-1:0] cnt_next(input logic [C_CW-1:0] q,
                                               input logic wr_lo, input logic wr_hi,
                                               input logic inc, input logic [XLEN-1:0] wd);
    cnt_next = q;
    if (wr_lo)
      cnt_next[XLEN-1:0] = wd;
    else if (wr_hi)
      cnt_next[C_CW-1:XLEN] = wd;
    else if (inc)
      cnt_next = q + C_CW'(1);
  endfunction

  assign w_commit = csr_we && !exception_pending && !stall;
  assign w_wb_idx = csr_address_wb[4:0];
  assign w_wr_lo  = w_commit && (csr_address_wb[11:5] == 7'b1011000);
  assign w_wr_hi  = w_commit && (csr_address_wb[11:5] == 7'b1011100);
  assign w_tick   = (presc_q == C_PW'(TIMER_DIV - 1));

  always_comb begin
    for (int k = 0; k < C_NH; k++) begin
      w_ev_hit[k] = 1'b0;
      for (int e = 0; e < N_EVENTS; e++)
        if ((event_q[k] == 8'(e + 1)) && hpm_event[e]) w_ev_hit[k] = 1'b1;
    end
  end

  always_comb begin
    mcycle_d   = cnt_next(mcycle_q, w_wr_lo && (w_wb_idx == 5'd0), w_wr_hi && (w_wb_idx == 5'd0),
                          !inhibit_q[0], csr_wb);
    minstret_d = cnt_next(minstret_q, w_wr_lo && (w_wb_idx == 5'd2), w_wr_hi && (w_wb_idx == 5'd2),
                          instr_retire && !stall && !inhibit_q[2], csr_wb);
    for (int k = 0; k < C_NH; k++) begin
      hpm_d[k]   = '0;
      event_d[k] = '0;
      if (k < N_HPM) begin
        hpm_d[k]   = cnt_next(hpm_q[k], w_wr_lo && (w_wb_idx == 5'(k + 3)),
                              w_wr_hi && (w_wb_idx == 5'(k + 3)),
                              w_ev_hit[k] && !inhibit_q[k + 3], csr_wb);
        event_d[k] = event_q[k];
        if (w_commit && (csr_address_wb == 12'h323 + 12'(k)))
          event_d[k] = (csr_wb <= XLEN'(N_EVENTS)) ? csr_wb[7:0] : 8'd0;
      end
    end
    inhibit_d = inhibit_q;
    if (w_commit && (csr_address_wb == 12'h320)) inhibit_d = csr_wb[31:0] & C_INH_MASK;
`ifdef CSR_USER_COUNTERS_EN
    counteren_d = (w_commit && (csr_address_wb == 12'h306)) ? csr_wb[31:0] : counteren_q;
`else
    counteren_d = '0;
`endif
    mtime_d = w_tick ? mtime_q + C_CW'(1) : mtime_q;
    presc_d = w_tick ? '0 : presc_q + C_PW'(1);
    // Software writes to mtime restart the prescaler so the next tick is a full period away.
    if (w_commit && (csr_address_wb == 12'h7C0)) begin
      mtime_d = {mtime_q[C_CW-1:XLEN], csr_wb};
      presc_d = '0;
    end else if (w_commit && (csr_address_wb == 12'h7C1)) begin
      mtime_d = {csr_wb, mtime_q[XLEN-1:0]};
      presc_d = '0;
    end
    mtimecmp_d = mtimecmp_q;
    if (w_commit && (csr_address_wb == 12'h7C2)) mtimecmp_d[XLEN-1:0]    = csr_wb;
    if (w_commit && (csr_address_wb == 12'h7C3)) mtimecmp_d[C_CW-1:XLEN] = csr_wb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q    <= '0;
      minstret_q  <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      presc_q     <= '0;
      inhibit_q   <= '0;
      counteren_q <= '0;
      m_timer_q   <= 1'b0;
      for (int k = 0; k < C_NH; k++) begin
        hpm_q[k]   <= '0;
        event_q[k] <= '0;
      end
    end else begin
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      presc_q     <= presc_d;
      inhibit_q   <= inhibit_d;
      counteren_q <= counteren_d;
      m_timer_q   <= (mtime_q >= mtimecmp_q);
      for (int k = 0; k < C_NH; k++) begin
        hpm_q[k]   <= hpm_d[k];
        event_q[k] <= event_d[k];
      end
    end
  end

  // Read side; index 1 of the counter window is time, visible only through the user shadow.
  assign w_rd_idx = csr_address_r[4:0];
  assign w_rd_lo  = (csr_address_r[11:5] == 7'b1011000) && (w_rd_idx != 5'd1);
  assign w_rd_hi  = (csr_address_r[11:5] == 7'b1011100) && (w_rd_idx != 5'd1);
  assign w_rd_inh = (csr_address_r == 12'h320);
  assign w_rd_evt = (csr_address_r[11:5] == 7'b0011001) && (w_rd_idx >= 5'd3);
  assign w_rd_en  = (csr_address_r == 12'h306);
  assign w_rd_tim = (csr_address_r[11:2] == 10'b0111110000);
  assign w_mach   = w_rd_lo || w_rd_hi || w_rd_inh || w_rd_evt || w_rd_en || w_rd_tim;
`ifdef CSR_USER_COUNTERS_EN
  assign w_usr    = (csr_address_r[11:5] == 7'b1100000) || (csr_address_r[11:5] == 7'b1100100);
`else
  assign w_usr    = 1'b0;
`endif

  always_comb begin
    w_cnt_val = '0;
    case (w_rd_idx)
      5'd0:    w_cnt_val = mcycle_q;
      5'd1:    w_cnt_val = mtime_q;
      5'd2:    w_cnt_val = minstret_q;
      default: begin
        for (int k = 0; k < C_NH; k++)
          if ((k < N_HPM) && (w_rd_idx == 5'(k + 3))) w_cnt_val = hpm_q[k];
      end
    endcase
  end

  always_comb begin
    w_val = '0;
    if (w_rd_lo || w_rd_hi || w_usr)
      w_val = csr_address_r[7] ? w_cnt_val[C_CW-1:XLEN] : w_cnt_val[XLEN-1:0];
    if (w_rd_inh) w_val[31:0] = inhibit_q;
    if (w_rd_en)  w_val[31:0] = counteren_q;
    if (w_rd_evt) begin
      for (int k = 0; k < C_NH; k++)
        if ((k < N_HPM) && (w_rd_idx == 5'(k + 3))) w_val[7:0] = event_q[k];
    end
    if (w_rd_tim) begin
      case (csr_address_r[1:0])
        2'd0:    w_val = mtime_q[XLEN-1:0];
        2'd1:    w_val = mtime_q[C_CW-1:XLEN];
        2'd2:    w_val = mtimecmp_q[XLEN-1:0];
        default: w_val = mtimecmp_q[C_CW-1:XLEN];
      endcase
    end
  end

  assign w_priv_fail = (current_mode != C_MODE_M) &&
                       (w_mach || (w_usr && !counteren_q[w_rd_idx]));
  assign csr_hit     = w_mach || w_usr;
  assign csr_illegal = w_priv_fail || (w_usr && csr_we_r);
  assign csr_data    = (csr_hit && !w_priv_fail) ? w_val : '0;
  assign m_timer     = m_timer_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_counters.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_csr_counters                                                 |
// | Brief    : Directed + random bench for csr_counters against a cycle model. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_csr_counters;
  localparam int XLEN = 32, N_HPM = 4, N_EVENTS = 8, TIMER_DIV = 4;

  logic clk = 1'b0;
  logic rst, csr_hit, csr_illegal, csr_we_r, csr_we, exception_pending, stall, instr_retire, m_timer;
  logic [1:0]          current_mode;
  logic [11:0]         csr_address_r, csr_address_wb;
  logic [XLEN-1:0]     csr_data, csr_wb;
  logic [N_EVENTS-1:0] hpm_event;
  int n_assert = 0, n_fail = 0;

  always #50 clk = ~clk;

  csr_counters #(.XLEN(XLEN), .N_HPM(N_HPM), .N_EVENTS(N_EVENTS), .TIMER_DIV(TIMER_DIV)) dut (
    .clk(clk), .rst(rst), .current_mode(current_mode), .csr_address_r(csr_address_r),
    .csr_data(csr_data), .csr_hit(csr_hit), .csr_illegal(csr_illegal), .csr_we_r(csr_we_r),
    .csr_address_wb(csr_address_wb), .csr_wb(csr_wb), .csr_we(csr_we),
    .exception_pending(exception_pending), .stall(stall), .instr_retire(instr_retire),
    .hpm_event(hpm_event), .m_timer(m_timer));

  // Behavioural model state, 64-bit counters as plain numbers.
  logic [63:0] m_cyc, m_ins, m_time, m_cmp;
  logic [63:0] m_hpm [N_HPM];
  int          m_evt [N_HPM];
  logic [31:0] m_inh, m_en;
  int          m_presc;
  bit          m_tmr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cyc = 0; m_ins = 0; m_time = 0; m_cmp = '1; m_inh = 0; m_en = 0; m_presc = 0; m_tmr = 0;
    for (int k = 0; k < N_HPM; k++) begin m_hpm[k] = 0; m_evt[k] = 0; end
  endfunction

  function automatic logic [31:0] inh_mask();
    logic [31:0] m = 0;
    for (int b = 0; b < 32; b++) if (b == 0 || b == 2 || (b >= 3 && b < 3 + N_HPM)) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] cnt(input logic [63:0] v, input bit wr, input logic [11:0] a,
                                      input logic [11:0] lo, input bit inc, input logic [31:0] wd);
    if (wr && a == lo) return {v[63:32], wd};
    if (wr && a == lo + 12'h080) return {wd, v[31:0]};
    return inc ? v + 64'd1 : v;
  endfunction

  task automatic model_edge();
    bit wr, inc;
    logic [11:0] a;
    logic [63:0] nh [N_HPM];
    if (rst) begin model_reset(); return; end
    wr = csr_we && !exception_pending && !stall;
    a  = csr_address_wb;
    m_tmr = (m_time >= m_cmp);
    for (int k = 0; k < N_HPM; k++) begin
      inc = 0;
      if (m_evt[k] >= 1 && m_evt[k] <= N_EVENTS && !m_inh[k + 3]) inc = hpm_event[m_evt[k] - 1];
      nh[k] = cnt(m_hpm[k], wr, a, 12'hB03 + 12'(k), inc, csr_wb);
    end
    m_cyc = cnt(m_cyc, wr, a, 12'hB00, !m_inh[0], csr_wb);
    m_ins = cnt(m_ins, wr, a, 12'hB02, instr_retire && !stall && !m_inh[2], csr_wb);
    for (int k = 0; k < N_HPM; k++) begin
      m_hpm[k] = nh[k];
      if (wr && a == 12'h323 + 12'(k)) m_evt[k] = (csr_wb <= N_EVENTS) ? int'(csr_wb) : 0;
    end
    if (wr && a == 12'h320) m_inh = csr_wb & inh_mask();
`ifdef CSR_USER_COUNTERS_EN
    if (wr && a == 12'h306) m_en = csr_wb;
`endif
    if (wr && (a == 12'h7C0 || a == 12'h7C1)) begin
      m_time = (a == 12'h7C0) ? {m_time[63:32], csr_wb} : {csr_wb, m_time[31:0]};
      m_presc = 0;
    end else if (m_presc == TIMER_DIV - 1) begin
      m_presc = 0; m_time = m_time + 64'd1;
    end else m_presc++;
    if (wr && a == 12'h7C2) m_cmp[31:0]  = csr_wb;
    if (wr && a == 12'h7C3) m_cmp[63:32] = csr_wb;
  endtask

  function automatic logic [63:0] m_cnt(input int idx);
    if (idx == 0) return m_cyc;
    if (idx == 1) return m_time;
    if (idx == 2) return m_ins;
    if (idx >= 3 && idx < 3 + N_HPM) return m_hpm[idx - 3];
    return 64'd0;
  endfunction

  task automatic rd(input string tag, input logic [11:0] a, input logic [1:0] mode, input bit wer);
    logic [31:0] ed = 0;
    logic [63:0] v;
    bit mach = 0, usr = 0, pf;
    int idx = int'(a[4:0]);
    csr_address_r = a; current_mode = mode; csr_we_r = wer;
    #1;
    if (a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) begin mach = 1; v = m_cnt(idx); ed = v[31:0]; end
    else if (a >= 12'hB80 && a <= 12'hB9F && a != 12'hB81) begin mach = 1; v = m_cnt(idx); ed = v[63:32]; end
    else if (a == 12'h320) begin mach = 1; ed = m_inh; end
    else if (a >= 12'h323 && a <= 12'h33F) begin mach = 1; ed = (idx - 3 < N_HPM) ? m_evt[idx - 3] : 0; end
    else if (a == 12'h306) begin mach = 1; ed = m_en; end
    else if (a == 12'h7C0) begin mach = 1; ed = m_time[31:0]; end
    else if (a == 12'h7C1) begin mach = 1; ed = m_time[63:32]; end
    else if (a == 12'h7C2) begin mach = 1; ed = m_cmp[31:0]; end
    else if (a == 12'h7C3) begin mach = 1; ed = m_cmp[63:32]; end
`ifdef CSR_USER_COUNTERS_EN
    else if (a >= 12'hC00 && a <= 12'hC1F) begin usr = 1; v = m_cnt(idx); ed = v[31:0]; end
    else if (a >= 12'hC80 && a <= 12'hC9F) begin usr = 1; v = m_cnt(idx); ed = v[63:32]; end
`endif
    pf = (mach && mode != 2'b11) || (usr && mode != 2'b11 && !m_en[idx]);
    if (pf) ed = 0;
    chk({tag, "_data"}, csr_data, ed);
    chk({tag, "_hit"}, csr_hit, mach || usr);
    chk({tag, "_illegal"}, csr_illegal, pf || (usr && wer));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_timer", m_timer, m_tmr);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_address_wb = a; csr_wb = d;
    tick();
    csr_we = 0;
  endtask

  logic [11:0] wlist [22] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB06,
                              12'hB83, 12'hB1F, 12'h320, 12'h323, 12'h324, 12'h325, 12'h326,
                              12'h33F, 12'h306, 12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'hC00, 12'hB05};
  logic [11:0] rlist [16] = '{12'hB00, 12'hB80, 12'hB01, 12'hB02, 12'hB03, 12'hB86, 12'hB9F,
                              12'h320, 12'h321, 12'h324, 12'h33F, 12'h306, 12'h7C1, 12'h7C2,
                              12'hC01, 12'hC83};

  initial begin
    int n;
    logic [11:0] a;
    logic [1:0] md;
    rst = 1; csr_we = 0; csr_we_r = 0; csr_address_wb = 0; csr_wb = 0; current_mode = 2'b11;
    csr_address_r = 0; exception_pending = 0; stall = 0; instr_retire = 0; hpm_event = 0;
    model_reset();
    tick(); tick();
    rst = 0;
    repeat (10) tick();
    rd("idle_b00", 12'hB00, 2'b11, 0); chk("mcycle_10", csr_data, 10);
    rd("idle_b80", 12'hB80, 2'b11, 0); chk("mcycle_hi_0", csr_data, 0);
    rd("idle_b02", 12'hB02, 2'b11, 0); chk("minstret_0", csr_data, 0);
    chk("m_timer_rst", m_timer, 0);
    rd("rst_cmp_hi", 12'h7C3, 2'b11, 0); chk("mtimecmp_ones", csr_data, 32'hFFFF_FFFF);

    // Low-half write then carry into the high half on the next free cycle.
    wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("wrap_lo", 12'hB00, 2'b11, 0); chk("wrap_lo_c", csr_data, 0);
    rd("wrap_hi", 12'hB80, 2'b11, 0); chk("wrap_hi_c", csr_data, 1);
    wr(12'h320, 32'h1);
    repeat (5) tick();
    rd("inh_b00", 12'hB00, 2'b11, 0); chk("inh_frozen", csr_data, 1);
    wr(12'h320, 32'hFFFF_FFFF);
    rd("inh_mask", 12'h320, 2'b11, 0); chk("inh_mask_c", csr_data, 32'h7D);
    wr(12'h320, 32'h0);

    wr(12'h323, 32'd2);
    repeat (3) begin hpm_event = 8'b10; tick(); hpm_event = 0; tick(); end
    repeat (2) begin hpm_event = 8'b01; tick(); hpm_event = 0; tick(); end
    rd("hpm3", 12'hB03, 2'b11, 0); chk("hpm3_3", csr_data, 3);
    wr(12'h323, N_EVENTS);
    rd("evt_max", 12'h323, 2'b11, 0); chk("evt_max_c", csr_data, N_EVENTS);
    wr(12'h323, N_EVENTS + 1);
    rd("evt_warl", 12'h323, 2'b11, 0); chk("evt_warl_c", csr_data, 0);

    wr(12'h7C2, 32'd3);
    wr(12'h7C3, 32'd0);
    wr(12'h7C0, 32'd0);
    tick();
    chk("tmr_low_after_wr", m_timer, 0);
    n = 1;
    while (!m_timer && n < 30) begin tick(); n++; end
    chk("tmr_latency", n, 13);
    wr(12'h7C2, 32'hFFFF_FFFF);
    tick();
    chk("tmr_clear", m_timer, 0);

    csr_we = 1; csr_address_wb = 12'hB02; csr_wb = 32'h1234; exception_pending = 1;
    tick();
    exception_pending = 0; stall = 1; instr_retire = 1;
    tick();
    csr_we = 0; stall = 0; instr_retire = 0;
    rd("squash", 12'hB02, 2'b11, 0); chk("squash_c", csr_data, 0);
    instr_retire = 1; tick(); tick(); instr_retire = 0;
    rd("retire", 12'hB02, 2'b11, 0); chk("retire_c", csr_data, 2);

    rd("u_mach", 12'hB00, 2'b00, 0); chk("u_mach_ill", csr_illegal, 1); chk("u_mach_data", csr_data, 0);
`ifdef CSR_USER_COUNTERS_EN
    rd("u_cyc0", 12'hC00, 2'b00, 0); chk("u_cyc0_ill", csr_illegal, 1);
    wr(12'h306, 32'h1);
    rd("u_cyc1", 12'hC00, 2'b00, 0); chk("u_cyc1_ill", csr_illegal, 0);
    chk("u_cyc1_data", csr_data, m_cyc[31:0]);
    rd("u_cycw", 12'hC00, 2'b00, 1); chk("u_cycw_ill", csr_illegal, 1);
`else
    rd("no_usr", 12'hC00, 2'b11, 0); chk("no_usr_hit", csr_hit, 0);
    wr(12'h306, 32'hFFFF_FFFF);
    rd("en_zero", 12'h306, 2'b11, 0); chk("en_zero_c", csr_data, 0);
`endif

    repeat (300) begin
      a = wlist[$urandom_range(0, 21)];
      csr_we = ($urandom_range(0, 3) == 0);
      csr_address_wb = a;
      if (a >= 12'h323 && a <= 12'h33F) csr_wb = $urandom_range(0, N_EVENTS + 2);
      else if ($urandom_range(0, 3) == 0) csr_wb = 32'hFFFF_FFFF;
      else csr_wb = $urandom;
      exception_pending = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 7) == 0);
      instr_retire = $urandom_range(0, 1);
      hpm_event = N_EVENTS'($urandom);
      case ($urandom_range(0, 2))
        0: md = 2'b00;
        1: md = 2'b01;
        default: md = 2'b11;
      endcase
      rd("rand", rlist[$urandom_range(0, 15)], md, $urandom_range(0, 1));
      tick();
    end

    csr_we = 1; csr_address_wb = 12'hB00; csr_wb = 32'h55;
    rst = 1;
    tick();
    rst = 0; csr_we = 0;
    rd("midrst", 12'hB00, 2'b11, 0); chk("midrst_c", csr_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
